pacman_spi_frame_tx: RTL

SPI master that streams a pacman board frame to the LED-matrix FPGA as the ASCII tile stream that board already decodes. It sits on the game-logic side of the link, in the Pi's place. It reads 3-bit tile codes from a frame buffer, encodes each code as one ASCII byte and shifts the bytes out MSB-first in SPI mode 0. It also captures the byte shifted back on `miso` (the slave's keypad state) for the game logic.

---
 rtl/pacman_spi_frame_tx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pacman_spi_frame_tx.sv
// SPI mode-0 master: streams a frame of 3-bit tile codes as ASCII bytes, MSB first,
// and captures the byte clocked back on miso. One byte every 17*CLK_DIV+2 cycles.
module pacman_spi_frame_tx #(
  parameter int CLK_DIV  = 4,
  parameter int N_PIXELS = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_data,
  output logic              sck,
  output logic              mosi,
  output logic              cs_n,
  input  logic              miso,
  output logic [7:0]        rx_byte,
  output logic              bad_code
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0]     DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]     DIV_HOLD = DW'(CLK_DIV);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(N_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_GAP, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     div_cnt;
  logic [3:0]        half_cnt;
  logic [ADDR_W-1:0] pix;
  logic [7:0]        tx_sr;
  logic [7:0]        rx_sr;
  logic [7:0]        enc_byte;
  logic              enc_bad;
  logic              half_end;
  logic              last_pix;
  logic              gap_end;

  always_comb begin
    enc_bad = 1'b0;
    case (rd_data)
      3'b100:  enc_byte = 8'h57;
      3'b010:  enc_byte = 8'h46;
      3'b001:  enc_byte = 8'h49;
      3'b111:  enc_byte = 8'h4F;
      default: begin
        enc_byte = 8'h20;
        enc_bad  = 1'b1;
      end
    endcase
  end

  assign half_end = (div_cnt == DIV_LAST);
  assign last_pix = (pix == PIX_LAST);
  // The final gap holds cs_n low one extra cycle before the frame is released.
  assign gap_end  = (div_cnt == (last_pix ? DIV_HOLD : DIV_LAST));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (half_end && half_cnt == 4'd15) state_nxt = S_GAP;
      S_GAP:   if (gap_end) state_nxt = last_pix ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix      <= '0;
      div_cnt  <= '0;
      half_cnt <= '0;
      sck      <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_byte  <= '0;
      bad_code <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pix      <= '0;
          bad_code <= 1'b0;
        end
        S_LOAD: begin
          tx_sr    <= enc_byte;
          div_cnt  <= '0;
          half_cnt <= '0;
          if (enc_bad) bad_code <= 1'b1;
        end
        S_SHIFT: begin
          if (half_end) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 4'd1;
            if (!half_cnt[0]) begin
              sck   <= 1'b1;
              rx_sr <= {rx_sr[6:0], miso};
            end else begin
              sck   <= 1'b0;
              tx_sr <= {tx_sr[6:0], 1'b0};
              if (half_cnt == 4'd15) rx_byte <= rx_sr;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_GAP: begin
          if (gap_end) begin
            div_cnt <= '0;
            if (!last_pix) pix <= pix + ADDR_W'(1);
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_addr = pix;

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
    cs_n = (state == S_IDLE) || (state == S_DONE);
    mosi = 1'b0;
    if (state == S_LOAD)       mosi = enc_byte[7];
    else if (state == S_SHIFT) mosi = tx_sr[7];
  end

endmodule
